// File: rtl/img2col_pkg.sv
// rtl/img2col_pkg.sv - shared types and constants for the img2col stage
package img2col_pkg;

    localparam int COL_IDX_W      = 6;
    // PU count shared with the mapping controller so both sides size the bank alike
    localparam int DEFAULT_NUM_PU = 28;
    localparam int DEFAULT_VEC_W  = 72;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/img2col_drain_ctrl.sv
// rtl/img2col_drain_ctrl.sv - in-order PU column drain onto one registered valid/ready stream
module img2col_drain_ctrl
    import img2col_pkg::*;
#(
    parameter int NUM_PU = DEFAULT_NUM_PU,
    parameter int VEC_W  = DEFAULT_VEC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [5:0]              num_rounds,
    input  logic                    abort,
    input  logic [NUM_PU-1:0]       pu_valid,
    input  logic [NUM_PU*VEC_W-1:0] pu_data,
    output logic [NUM_PU-1:0]       pu_ack,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VEC_W-1:0]        out_data,
    output logic [5:0]              out_col,
    output logic [5:0]              out_round,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    drain_state_t         state;
    drain_state_t         state_nxt;
    logic [COL_IDX_W-1:0] ptr;
    logic [COL_IDX_W-1:0] round;
    logic [COL_IDX_W-1:0] num_rounds_q;
    logic [63:0]          pu_valid_ext;
    logic                 load;
    logic                 ptr_at_end;
    logic                 final_col;
    logic                 kill;
    logic                 accept_start;

    // widened so the 6-bit pointer indexes it without a width mismatch
    assign pu_valid_ext = 64'(pu_valid);
    assign ptr_at_end   = (ptr == COL_IDX_W'(NUM_PU - 1));
    assign final_col    = ptr_at_end && (round == num_rounds_q - 6'd1);
    assign kill         = abort && (state != IDLE);
    assign accept_start = (state == IDLE) && start && (num_rounds != 6'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_start) state_nxt = RUN;
            RUN:     if (load && final_col) state_nxt = FLUSH;
            FLUSH:   if (out_valid && out_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        load   = 1'b0;
        pu_ack = '0;
        busy   = (state != IDLE);
        done   = (state == DONE);
        if (state == RUN && !abort && pu_valid_ext[ptr] && (!out_valid || out_ready)) begin
            load   = 1'b1;
            pu_ack = NUM_PU'(1) << ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            round        <= '0;
            num_rounds_q <= '0;
        end else if (kill) begin
            ptr   <= '0;
            round <= '0;
        end else if (accept_start) begin
            num_rounds_q <= num_rounds;
            ptr          <= '0;
            round        <= '0;
        end else if (load) begin
            if (ptr_at_end) begin
                ptr   <= '0;
                // the final wrap returns round to 0 so it never exceeds num_rounds_q-1
                round <= final_col ? '0 : round + 6'd1;
            end else begin
                ptr <= ptr + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else if (kill) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= pu_data[int'(ptr)*VEC_W +: VEC_W];
            out_col   <= ptr;
            out_round <= round;
            out_last  <= final_col;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_img2col_drain_ctrl.sv
// tb/tb_img2col_drain_ctrl.sv - scoreboard bench for img2col_drain_ctrl
module tb_img2col_drain_ctrl;

    localparam int NUM_PU = 28;
    localparam int VEC_W  = 72;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [5:0]              num_rounds;
    logic                    abort;
    logic [NUM_PU-1:0]       pu_valid;
    logic [NUM_PU*VEC_W-1:0] pu_data;
    logic [NUM_PU-1:0]       pu_ack;
    logic                    out_valid;
    logic                    out_ready;
    logic [VEC_W-1:0]        out_data;
    logic [5:0]              out_col;
    logic [5:0]              out_round;
    logic                    out_last;
    logic                    busy;
    logic                    done;

    img2col_drain_ctrl #(.NUM_PU(NUM_PU), .VEC_W(VEC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rounds(num_rounds), .abort(abort),
        .pu_valid(pu_valid), .pu_data(pu_data), .pu_ack(pu_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_round(out_round), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VEC_W-1:0] data;
        logic [5:0]       col;
        logic [5:0]       round;
        logic             last;
    } beat_t;

    beat_t             exp_q[$];
    int                vectors    = 0;
    int                miscompares = 0;
    int                pu_cnt[NUM_PU] = '{default: 0};
    logic [NUM_PU-1:0] ack_seen   = '0;
    int                beats      = 0;
    int                done_cnt   = 0;
    int                cyc        = 0;
    int                done_cyc   = 0;
    logic              last_hs_d  = 1'b0;

    task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] mk(input int c, input int k);
        return {8'(c), 16'(k), 16'(c * 7 + k * 13), 32'(32'hC0DE0000 ^ (c << 8) ^ k)};
    endfunction

    always @(posedge clk) cyc++;

    // PU bank model: an acked PU presents its next column after the edge
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_PU; i++) begin
            if (ack_seen[i]) pu_cnt[i]++;
            pu_data[i*VEC_W +: VEC_W] = mk(i, pu_cnt[i]);
        end
    end

    always @(negedge clk) begin
        logic  hs_last;
        beat_t e;
        hs_last  = 1'b0;
        ack_seen = rst ? '0 : pu_ack;
        if (!rst && !abort && out_valid && out_ready) begin
            beats++;
            hs_last = out_last;
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", out_data, e.data);
                check("beat_col", out_col, e.col);
                check("beat_round", out_round, e.round);
                check("beat_last", out_last, e.last);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_after_last", last_hs_d, 1);
        end
        last_hs_d = hs_last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input int nr);
        beat_t b;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < NUM_PU; c++) begin
                b.data  = mk(c, pu_cnt[c] + r);
                b.col   = 6'(c);
                b.round = 6'(r);
                b.last  = (r == nr - 1) && (c == NUM_PU - 1);
                exp_q.push_back(b);
            end
        end
        start      = 1'b1;
        num_rounds = 6'(nr);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  base;
        bit  seen;
        base = done_cnt;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != base) seen = 1;
        end
        #1;
        if (!seen) check("done_timeout", 0, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_beats(input int base, input int n);
        bit hit;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            samp();
            if (beats - base >= n) hit = 1;
        end
        if (!hit) check("beat_timeout", 0, 1);
    endtask

    task automatic check_reset_vals();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pu_ack", pu_ack, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_col", out_col, 0);
        check("rst_out_round", out_round, 0);
        check("rst_out_last", out_last, 0);
    endtask

    initial begin
        int e_cyc, base, dbase;
        logic [VEC_W-1:0] hold_data;
        logic [5:0]       hold_col;

        rst = 1'b1; start = 1'b0; abort = 1'b0; num_rounds = '0;
        pu_valid = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        samp();
        check_reset_vals();

        // single round, full throughput
        pu_valid = '1;
        tick();
        base = beats;
        start_job(1);
        e_cyc = cyc;
        samp();
        check("start_busy", busy, 1);
        check("start_first_ack", pu_ack, 1);
        samp();
        check("start_out_valid", out_valid, 1);
        wait_done(200);
        check("r1_beats", beats - base, NUM_PU);
        check("r1_done_cycle", done_cyc - e_cyc, NUM_PU + 1);
        samp();
        check("r1_busy_after", busy, 0);
        check("r1_done_pulse", done, 0);

        // strict ordering: only PU5 ready while ptr is 0
        pu_valid = 28'(1) << 5;
        tick();
        start_job(1);
        for (int i = 0; i < 4; i++) begin
            samp();
            check("order_no_ack", pu_ack, 0);
            check("order_no_valid", out_valid, 0);
        end
        tick();
        pu_valid = '1;
        samp();
        check("order_ack0", pu_ack, 1);
        samp();
        check("order_valid", out_valid, 1);
        check("order_col0", out_col, 0);

        // backpressure for three cycles
        tick();
        out_ready = 1'b0;
        samp();
        hold_data = out_data;
        hold_col  = out_col;
        check("bp_ack", pu_ack, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            samp();
            check("bp_data_stable", out_data, hold_data);
            check("bp_col_stable", out_col, hold_col);
            check("bp_ack", pu_ack, 0);
            check("bp_valid", out_valid, 1);
        end
        tick();
        out_ready = 1'b1;
        samp();
        check("bp_release_ack", pu_ack, 28'(1) << (hold_col + 6'd1));
        wait_done(200);

        // num_rounds of zero is ignored
        start_job(0);
        samp();
        check("zero_busy", busy, 0);
        repeat (3) tick();
        check("zero_busy_later", busy, 0);
        check("zero_valid", out_valid, 0);

        // two rounds, with a stray start mid-job
        base = beats;
        start_job(2);
        repeat (10) tick();
        start = 1'b1;
        num_rounds = 6'd1;
        tick();
        start = 1'b0;
        wait_done(300);
        check("r2_beats", beats - base, 2 * NUM_PU);

        // abort at beat 10
        tick();
        base  = beats;
        dbase = done_cnt;
        start_job(1);
        wait_beats(base, 10);
        tick();
        abort = 1'b1;
        samp();
        check("abort_ack", pu_ack, 0);
        tick();
        abort = 1'b0;
        samp();
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        exp_q.delete();
        repeat (6) tick();
        check("abort_no_done", done_cnt - dbase, 0);

        // reset mid-job at beat 15, then a fresh job
        base = beats;
        start_job(1);
        wait_beats(base, 15);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        samp();
        check_reset_vals();
        exp_q.delete();
        tick();
        base = beats;
        start_job(1);
        wait_done(200);
        check("post_rst_beats", beats - base, NUM_PU);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
